// File: rtl/sw_event_pkg.sv
// Shared types and defaults for the switch event decoder.
package sw_event_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DOWN,
    LONG_HELD,
    WAIT_2ND,
    DOWN2
  } state_t;

  localparam int TICK_DIV_DEF     = 50000;
  localparam int LONG_TICKS_DEF   = 1000;
  localparam int DCLICK_TICKS_DEF = 300;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sw_tick_gen.sv
// Timing prescaler: one TICK per TICK_DIV cycles, restartable so durations
// are always measured from the most recent switch edge.
module sw_tick_gen
  import sw_event_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic CLK,
  input  logic RESET,
  input  logic RESTART,
  output logic TICK
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      pre <= '0;
    end else if (RESTART || pre == LAST) begin
      pre <= '0;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  // An edge restarts the measurement, so it also suppresses a coincident tick.
  assign TICK = (pre == LAST) && !RESTART;

endmodule

// File: rtl/sw_event_decode.sv
// Turns a debounced switch level into single-cycle PRESS/RELEASE/SHORT/LONG
// events and a HOLD level; define DOUBLE_CLICK_EN to add double-click detection.
module sw_event_decode
  import sw_event_pkg::*;
#(
  parameter int TICK_DIV     = TICK_DIV_DEF,
  parameter int LONG_TICKS   = LONG_TICKS_DEF,
  parameter int DCLICK_TICKS = DCLICK_TICKS_DEF
) (
  input  logic CLK,
  input  logic RESET,
  input  logic SW_IN,
  output logic PRESS,
  output logic RELEASE,
  output logic SHORT,
  output logic LONG,
  output logic DOUBLE,
  output logic HOLD
);

  localparam int CW = $clog2(max_int(LONG_TICKS, DCLICK_TICKS) + 1);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_TICKS - 1);

  state_t        state;
  logic          sw_d;
  logic [CW-1:0] cnt;
  logic          rise;
  logic          fall;
  logic          edge_any;
  logic          tick;

  assign rise     = SW_IN & ~sw_d;
  assign fall     = ~SW_IN & sw_d;
  assign edge_any = rise | fall;

  sw_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .CLK    (CLK),
    .RESET  (RESET),
    .RESTART(edge_any),
    .TICK   (tick)
  );

`ifdef DOUBLE_CLICK_EN
  localparam logic [CW-1:0] DCLICK_LAST = CW'(DCLICK_TICKS - 1);
`else
  assign DOUBLE = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      // Loading 1 keeps a key held through reset from looking like a new press.
      sw_d    <= 1'b1;
      cnt     <= '0;
      state   <= IDLE;
      PRESS   <= 1'b0;
      RELEASE <= 1'b0;
      SHORT   <= 1'b0;
      LONG    <= 1'b0;
      HOLD    <= 1'b0;
`ifdef DOUBLE_CLICK_EN
      DOUBLE  <= 1'b0;
`endif
    end else begin
      sw_d    <= SW_IN;
      PRESS   <= 1'b0;
      RELEASE <= 1'b0;
      SHORT   <= 1'b0;
      LONG    <= 1'b0;
`ifdef DOUBLE_CLICK_EN
      DOUBLE  <= 1'b0;
`endif
      if (edge_any) begin
        cnt <= '0;
      end else if (tick && cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (rise) begin
            PRESS <= 1'b1;
            state <= DOWN;
          end
        end
        DOWN: begin
          if (fall) begin
            RELEASE <= 1'b1;
`ifdef DOUBLE_CLICK_EN
            state   <= WAIT_2ND;
`else
            SHORT   <= 1'b1;
            state   <= IDLE;
`endif
          end else if (tick && cnt == LONG_LAST) begin
            LONG  <= 1'b1;
            HOLD  <= 1'b1;
            state <= LONG_HELD;
          end
        end
        LONG_HELD: begin
          if (fall) begin
            RELEASE <= 1'b1;
            HOLD    <= 1'b0;
            state   <= IDLE;
          end
        end
`ifdef DOUBLE_CLICK_EN
        WAIT_2ND: begin
          // A rise on the expiry cycle still counts as the second click.
          if (rise) begin
            PRESS  <= 1'b1;
            DOUBLE <= 1'b1;
            state  <= DOWN2;
          end else if (tick && cnt == DCLICK_LAST) begin
            SHORT <= 1'b1;
            state <= IDLE;
          end
        end
        DOWN2: begin
          if (fall) begin
            RELEASE <= 1'b1;
            state   <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
